// File: rtl/grf_wb_arbiter.sv
// Purpose: merges main-pipeline W-stage writes and buffered MDU results onto the single GRF write port.
// Latency: pipeline write appears on A3/WD/PC one edge after request; an MDU write needs at least 2 edges (push, then pop).
// Backpressure: pipeline is never stalled; MDU is held off through mdu_ready when the write buffer is full.
//
// Ports:
//   clk, reset              - rising-edge clock, synchronous active-low reset
//   pipe_valid/a3/wd/pc     - pipeline write request (a3==0 means no write)
//   mdu_valid/ready/a3/wd/pc- MDU write request, valid/ready handshake into the buffer
//   q_addr, q_hit           - hazard query: does any buffered MDU write target q_addr
//   count                   - number of buffered MDU writes
//   A3, WD, PC              - registered GRF write port (A3==0 means no write)
module grf_wb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pipe_valid,
  input  logic [4:0]               pipe_a3,
  input  logic [31:0]              pipe_wd,
  input  logic [31:0]              pipe_pc,
  input  logic                     mdu_valid,
  output logic                     mdu_ready,
  input  logic [4:0]               mdu_a3,
  input  logic [31:0]              mdu_wd,
  input  logic [31:0]              mdu_pc,
  input  logic [4:0]               q_addr,
  output logic                     q_hit,
  output logic [$clog2(DEPTH):0]   count,
  output logic [4:0]               A3,
  output logic [31:0]              WD,
  output logic [31:0]              PC
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
  } wb_ent_t;

  wb_ent_t       mem [DEPTH];
  wb_ent_t       head;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] off;
  logic          pipe_live;
  logic          pop;
  logic          push;

  // A pipeline request with a3==0 carries no write and lets the buffer drain.
  assign pipe_live = pipe_valid && (pipe_a3 != 5'd0);
  assign pop       = !pipe_live && (count != '0);

  // Ready looks only at the registered count, never at a same-cycle pop,
  // so there is no combinational path from pipe_valid to mdu_ready.
  assign mdu_ready = reset && (count < CW'(DEPTH));

  // Writes to r0 complete the handshake but are dropped.
  assign push = mdu_valid && mdu_ready && (mdu_a3 != 5'd0);

  assign head = mem[rd_ptr];

  // An entry is live if its distance from the read pointer is below count;
  // popped slots keep stale data and must not produce a hit.
  always_comb begin
    q_hit = 1'b0;
    off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - rd_ptr;
      if ((q_addr != 5'd0) && ({1'b0, off} < count) && (mem[i].a3 == q_addr)) begin
        q_hit = 1'b1;
      end
    end
  end

  // Storage needs no reset: liveness is governed entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{a3: mdu_a3, wd: mdu_wd, pc: mdu_pc};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      A3     <= 5'd0;
      WD     <= 32'd0;
      PC     <= 32'd0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pipe_live) begin
        A3 <= pipe_a3;
        WD <= pipe_wd;
        PC <= pipe_pc;
      end else if (pop) begin
        A3     <= head.a3;
        WD     <= head.wd;
        PC     <= head.pc;
        rd_ptr <= rd_ptr + AW'(1);
      end else begin
        // Idle cycle: no write; WD/PC keep the last written values for the trace.
        A3 <= 5'd0;
      end

      // DEPTH is a power of two, so pointers wrap naturally.
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
